isl58315_pulse_seq: RTL

Register-programmed pulse sequencer that turns the ISL58315 driver's AXI4-Lite configuration registers into the laser-driver pin timing: enable settle, then a train of `cfg_count` pulses of programmable width and period. It sits directly downstream of the AXI4-Lite register slave in the same IP and runs in the AXI clock domain. Its outputs drive the ISL58315 enable and pulse pins through the IP top-level.

---
 rtl/isl58315_pkg.sv | 21 ++
 rtl/isl58315_tick_cnt.sv | 37 +++
 rtl/isl58315_pulse_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/isl58315_pkg.sv
// Shared types, default widths and the start-time configuration check
// for the ISL58315 pulse sequencer.
package isl58315_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int NUM_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HIGH   = 2'd2,
        ST_LOW    = 2'd3
    } state_t;

    // A pulse needs at least one high cycle and at least one low cycle.
    function automatic logic cfg_valid(input logic [63:0] width,
                                       input logic [63:0] period);
        return (width != 64'd0) && (period > width);
    endfunction

endpackage

// File: rtl/isl58315_tick_cnt.sv
// Loadable down-counter that times the settle, high and low phases.
// It holds at zero until the next load.
module isl58315_tick_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/isl58315_pulse_seq.sv
// ISL58315 enable/pulse sequencer: enable settle, then a train of pulses with
// programmable width, period and count, abortable by stop.
module isl58315_pulse_seq
    import isl58315_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             s00_axi_aclk,
    input  logic             s00_axi_aresetn,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [NUM_W-1:0] cfg_count,
    output logic             ld_en,
    output logic             ld_pulse,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             cfg_err,
    output logic [NUM_W-1:0] pulse_cnt
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [NUM_W-1:0] count_q, count_d;
    logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             ld_en_q, ld_en_d;
    logic             ld_pulse_q, ld_pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;
    logic             enter_high;

    isl58315_tick_cnt #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk      (s00_axi_aclk),
        .rst_n    (s00_axi_aresetn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        low_d       = low_q;
        count_d     = count_q;
        pulse_cnt_d = pulse_cnt_q;
        aborted_d   = aborted_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        ld_pulse_d  = 1'b0;
        cnt_load    = 1'b0;
        cnt_val     = cfg_delay;
        enter_high  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (cfg_valid(64'(cfg_width), 64'(cfg_period))) begin
                        width_d     = cfg_width;
                        low_d       = cfg_period - cfg_width;
                        count_d     = cfg_count;
                        pulse_cnt_d = '0;
                        aborted_d   = 1'b0;
                        cnt_load    = 1'b1;
                        cnt_val     = cfg_delay;
                        state_d     = ST_SETTLE;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                enter_high = cnt_zero;
            end
            ST_HIGH: begin
                ld_pulse_d = 1'b1;
                if (cnt_zero) begin
                    ld_pulse_d = 1'b0;
                    cnt_load   = 1'b1;
                    cnt_val    = low_q - CNT_W'(1);
                    state_d    = ST_LOW;
                end
            end
            ST_LOW: begin
                if (cnt_zero) begin
                    if ((count_q != '0) && (pulse_cnt_q == count_q)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        enter_high = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_high) begin
            state_d    = ST_HIGH;
            ld_pulse_d = 1'b1;
            cnt_load   = 1'b1;
            cnt_val    = width_q - CNT_W'(1);
            if (pulse_cnt_q != '1) begin
                pulse_cnt_d = pulse_cnt_q + NUM_W'(1);
            end
        end

        // Abort truncates any pulse in flight and pre-empts the normal flow.
        if (stop && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            ld_pulse_d  = 1'b0;
            done_d      = 1'b1;
            aborted_d   = 1'b1;
            pulse_cnt_d = pulse_cnt_q;
            cnt_load    = 1'b0;
        end

        busy_d  = (state_d != ST_IDLE);
        ld_en_d = busy_d;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q     <= ST_IDLE;
            width_q     <= '0;
            low_q       <= '0;
            count_q     <= '0;
            pulse_cnt_q <= '0;
            ld_en_q     <= 1'b0;
            ld_pulse_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            low_q       <= low_d;
            count_q     <= count_d;
            pulse_cnt_q <= pulse_cnt_d;
            ld_en_q     <= ld_en_d;
            ld_pulse_q  <= ld_pulse_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign ld_en     = ld_en_q;
    assign ld_pulse  = ld_pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign cfg_err   = cfg_err_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule
